// File: rtl/fnd_display_arbiter.sv
// Decides which 4-digit value drives the FND controller: the background value, or one of two
// overlay requesters. Each overlay keeps the display for TICK_DIV*HOLD_TICKS cycles.
module fnd_display_arbiter #(
   parameter int TICK_DIV   = 100_000,
   parameter int HOLD_TICKS = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bg_data,
   input  logic [1:0]  req,
   input  logic [15:0] req_data0,
   input  logic [15:0] req_data1,
   input  logic        cancel,
   output logic [1:0]  gnt,
   output logic [1:0]  owner,
   output logic [15:0] fnd_data
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

   // Handshake: req[n] is a level held with req_datan until the one-cycle gnt[n] pulse;
   // the requester may drop or keep req after that pulse.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW0 = 2'd1,
      SHOW1 = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [15:0]     fnd_n;
   logic [1:0]      gnt_n;
   logic            last_grant, last_grant_n;
   logic [PW-1:0]   presc, presc_n;
   logic [HW-1:0]   hold, hold_n;
   logic            expiry;
   logic            grant;
   logic            pick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         fnd_data   <= 16'h0000;
         gnt        <= 2'b00;
         last_grant <= 1'b1;
         presc      <= '0;
         hold       <= '0;
      end else begin
         state      <= state_n;
         fnd_data   <= fnd_n;
         gnt        <= gnt_n;
         last_grant <= last_grant_n;
         presc      <= presc_n;
         hold       <= hold_n;
      end
   end

   always_comb begin
      state_n      = state;
      fnd_n        = fnd_data;
      gnt_n        = 2'b00;
      last_grant_n = last_grant;
      presc_n      = '0;
      hold_n       = '0;
      grant        = 1'b0;
      expiry       = (presc == PRESC_LAST) && (hold == HOLD_LAST);

      // On a tie, favour whichever requester was not granted last.
      case (req)
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last_grant;
         default: pick = 1'b0;
      endcase

      case (state)
         IDLE: begin
            fnd_n = bg_data;
            grant = |req;
         end
         SHOW0, SHOW1: begin
            if (cancel) begin
               state_n = IDLE;
               fnd_n   = bg_data;
            end else if (expiry) begin
               grant = |req;
               if (!(|req)) begin
                  state_n = IDLE;
                  fnd_n   = bg_data;
               end
            end else if (presc == PRESC_LAST) begin
               hold_n = hold + HW'(1);
            end else begin
               presc_n = presc + PW'(1);
               hold_n  = hold;
            end
         end
         default: begin
            state_n = IDLE;
            fnd_n   = bg_data;
         end
      endcase

      if (grant) begin
         state_n      = pick ? SHOW1 : SHOW0;
         fnd_n        = pick ? req_data1 : req_data0;
         gnt_n        = pick ? 2'b10 : 2'b01;
         last_grant_n = pick;
      end
   end

   always_comb begin
      case (state)
         SHOW0:   owner = 2'd1;
         SHOW1:   owner = 2'd2;
         default: owner = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed bench for fnd_display_arbiter with a 12-cycle overlay (TICK_DIV=4, HOLD_TICKS=3).
module tb_fnd_display_arbiter;

   logic        clk;
   logic        reset;
   logic [15:0] bg_data;
   logic [1:0]  req;
   logic [15:0] req_data0;
   logic [15:0] req_data1;
   logic        cancel;
   logic [1:0]  gnt;
   logic [1:0]  owner;
   logic [15:0] fnd_data;

   int n_pass  = 0;
   int n_total = 0;
   logic [19:0] exp_q[$];
   logic [1:0]  prev_gnt = 2'b00;

   fnd_display_arbiter #(.TICK_DIV(4), .HOLD_TICKS(3)) dut (
      .clk(clk), .reset(reset), .bg_data(bg_data), .req(req),
      .req_data0(req_data0), .req_data1(req_data1), .cancel(cancel),
      .gnt(gnt), .owner(owner), .fnd_data(fnd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got owner=%0d gnt=%b fnd=%h, expected owner=%0d gnt=%b fnd=%h",
                  tag, obs[19:18], obs[17:16], obs[15:0], exp[19:18], exp[17:16], exp[15:0]);
   endtask

   // Push the expectation for the coming edge, then compare just after it.
   task automatic cycle(input string tag, input logic [1:0] e_owner, input logic [1:0] e_gnt,
                        input logic [15:0] e_fnd);
      logic [19:0] e;
      exp_q.push_back({e_owner, e_gnt, e_fnd});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(tag, {owner, gnt, fnd_data}, e);
   endtask

   // Grant pulses: never two bits, never the same bit on consecutive cycles.
   always @(negedge clk) begin
      if (!reset) begin
         check("gnt_onehot", {18'b0, gnt == 2'b11, 1'b0}, 20'd0);
         check("gnt_repeat", {18'b0, gnt & prev_gnt}, 20'd0);
      end
      prev_gnt = gnt;
   end

   initial begin
      reset = 1'b1; bg_data = 16'h1234; req = 2'b00;
      req_data0 = 16'h0000; req_data1 = 16'h0000; cancel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {owner, gnt, fnd_data}, {2'd0, 2'b00, 16'h0000});
      reset = 1'b0;

      // Background tracking with one-cycle latency
      cycle("bg_first", 2'd0, 2'b00, 16'h1234);
      bg_data = 16'h5678;
      cycle("bg_follow", 2'd0, 2'b00, 16'h5678);
      bg_data = 16'h1234;
      cycle("bg_back", 2'd0, 2'b00, 16'h1234);

      // Single overlay from requester 0, inputs changed during SHOW are ignored
      req = 2'b01; req_data0 = 16'hABCD;
      cycle("grant0", 2'd1, 2'b01, 16'hABCD);
      req = 2'b00; req_data0 = 16'h1111; bg_data = 16'h9999;
      for (int j = 1; j <= 11; j++) begin
         if (j == 10) bg_data = 16'h1234;
         cycle("show0_frozen", 2'd1, 2'b00, 16'hABCD);
      end
      cycle("expire_idle", 2'd0, 2'b00, 16'h1234);
      cycle("idle_after", 2'd0, 2'b00, 16'h1234);

      // Tie straight after reset: requester 0 first, requester 1 at expiry with no IDLE gap
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      req = 2'b11; req_data0 = 16'hAAAA; req_data1 = 16'hBBBB;
      cycle("tie_grant0", 2'd1, 2'b01, 16'hAAAA);
      req = 2'b10;
      for (int j = 1; j <= 11; j++) cycle("tie_hold0", 2'd1, 2'b00, 16'hAAAA);
      cycle("rr_grant1", 2'd2, 2'b10, 16'hBBBB);
      req = 2'b00;

      // Cancel five cycles into SHOW1
      for (int j = 1; j <= 4; j++) cycle("show1_hold", 2'd2, 2'b00, 16'hBBBB);
      cancel = 1'b1;
      cycle("cancel_show1", 2'd0, 2'b00, 16'h1234);
      cancel = 1'b0;
      cycle("after_cancel", 2'd0, 2'b00, 16'h1234);
      cancel = 1'b1; bg_data = 16'h4321;
      cycle("cancel_idle", 2'd0, 2'b00, 16'h4321);
      cancel = 1'b0; bg_data = 16'h1234;

      // Owner keeps requesting: no grant until expiry, then refresh with new data
      req = 2'b01; req_data0 = 16'hC0DE;
      cycle("own_grant", 2'd1, 2'b01, 16'hC0DE);
      req_data0 = 16'hDEAD;
      for (int j = 1; j <= 11; j++) cycle("own_blocked", 2'd1, 2'b00, 16'hC0DE);
      cycle("refresh", 2'd1, 2'b01, 16'hDEAD);
      req = 2'b00;
      for (int j = 1; j <= 3; j++) cycle("refresh_hold", 2'd1, 2'b00, 16'hDEAD);

      // Asynchronous reset mid-SHOW0, checked between edges
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", {owner, gnt, fnd_data}, {2'd0, 2'b00, 16'h0000});
      #1;
      reset = 1'b0;
      cycle("post_reset", 2'd0, 2'b00, 16'h1234);
      cycle("post_reset2", 2'd0, 2'b00, 16'h1234);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
